// File: rtl/dist_bus_packer.sv
// Collects serially arriving per-object hit distances into 2**WIDTH slots and presents
// them as one packed bus (slot k at bits [k*LENGTH +: LENGTH]) under a valid/ack handshake.
module dist_bus_packer #(
  parameter int WIDTH  = 3,
  parameter int LENGTH = 10
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [WIDTH-1:0]                in_idx,
  input  logic                            in_hit,
  input  logic [LENGTH-1:0]               in_dist,
  output logic [(2**WIDTH)*LENGTH-1:0]    out_bus,
  output logic                            out_valid,
  input  logic                            out_ack,
  output logic                            busy,
  output logic                            dup_err
);

  localparam int SLOTS = 2**WIDTH;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    PRESENT = 2'd2
  } state_t;

  // All-ones is the miss/infinity code, so an unfilled or missed slot never wins the min.
  localparam logic [LENGTH-1:0] MISS_CODE = {LENGTH{1'b1}};

  state_t            state;
  state_t            state_nxt;
  logic [LENGTH-1:0] slot_q [SLOTS];
  logic [SLOTS-1:0]  mask_q;
  logic [SLOTS-1:0]  idx_onehot;
  logic              accept;
  logic              already_filled;
  logic              last_fill;

  assign idx_onehot     = SLOTS'(1) << in_idx;
  assign accept         = in_valid && (state == COLLECT);
  assign already_filled = mask_q[in_idx];
  assign last_fill      = accept && !already_filled && ((mask_q | idx_onehot) == {SLOTS{1'b1}});

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: next_state gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = IDLE;
      COLLECT: if (last_fill) state_nxt = PRESENT;
      PRESENT: if (out_ack)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // start aborts any frame and wins over a simultaneous ack or write.
    if (start) begin
      state_nxt = COLLECT;
    end
  end

  // NOTE: the slot storage is reset on purpose: the miss code must be on out_bus from reset on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q <= '0;
      for (int i = 0; i < SLOTS; i++) begin
        slot_q[i] <= MISS_CODE;
      end
    end else if (start) begin
      mask_q <= '0;
      for (int i = 0; i < SLOTS; i++) begin
        slot_q[i] <= MISS_CODE;
      end
    end else if (accept && !already_filled) begin
      mask_q         <= mask_q | idx_onehot;
      slot_q[in_idx] <= in_hit ? in_dist : MISS_CODE;
    end
  end

  // A repeated index leaves the slot untouched and flags the next cycle only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dup_err <= 1'b0;
    end else begin
      dup_err <= !start && accept && already_filled;
    end
  end

  always_comb begin
    out_bus = '0;
    for (int k = 0; k < SLOTS; k++) begin
      out_bus[k*LENGTH +: LENGTH] = slot_q[k];
    end
  end

  assign in_ready  = (state == COLLECT);
  assign out_valid = (state == PRESENT);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_dist_bus_packer.sv
// Self-checking bench for dist_bus_packer: a frame-level reference model checked every
// cycle, directed scenarios with literal expectations, then randomized frames.
module tb_dist_bus_packer;

  localparam int WIDTH  = 3;
  localparam int LENGTH = 10;
  localparam int SLOTS  = 8;
  localparam int BUSW   = SLOTS * LENGTH;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_idx;
  logic              in_hit;
  logic [LENGTH-1:0] in_dist;
  logic [BUSW-1:0]   out_bus;
  logic              out_valid;
  logic              out_ack;
  logic              busy;
  logic              dup_err;

  int vectors = 0;
  int miscompares = 0;

  dist_bus_packer #(.WIDTH(WIDTH), .LENGTH(LENGTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_idx    (in_idx),
    .in_hit    (in_hit),
    .in_dist   (in_dist),
    .out_bus   (out_bus),
    .out_valid (out_valid),
    .out_ack   (out_ack),
    .busy      (busy),
    .dup_err   (dup_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [BUSW-1:0] act, input logic [BUSW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level reference: phase 0 = idle, 1 = collecting, 2 = presenting.
  int          m_phase = 0;
  logic [9:0]  m_slot [SLOTS];
  bit          m_filled [SLOTS];
  bit          m_dup = 0;

  initial for (int i = 0; i < SLOTS; i++) begin
    m_slot[i] = 10'h3FF;
    m_filled[i] = 0;
  end

  function automatic int filled_count();
    int n = 0;
    for (int i = 0; i < SLOTS; i++) n += m_filled[i];
    return n;
  endfunction

  function automatic logic [BUSW-1:0] model_bus();
    logic [BUSW-1:0] b = '0;
    for (int i = 0; i < SLOTS; i++) b[i*LENGTH +: LENGTH] = m_slot[i];
    return b;
  endfunction

  function automatic int argmin(input logic [BUSW-1:0] b);
    int best = 0;
    for (int i = 1; i < SLOTS; i++)
      if (b[i*LENGTH +: LENGTH] < b[best*LENGTH +: LENGTH]) best = i;
    return best;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0;
      m_dup = 0;
      for (int i = 0; i < SLOTS; i++) begin
        m_slot[i] = 10'h3FF;
        m_filled[i] = 0;
      end
    end else begin
      m_dup = 0;
      if (start) begin
        m_phase = 1;
        for (int i = 0; i < SLOTS; i++) begin
          m_slot[i] = 10'h3FF;
          m_filled[i] = 0;
        end
      end else if (m_phase == 1 && in_valid) begin
        if (m_filled[in_idx]) begin
          m_dup = 1;
        end else begin
          m_slot[in_idx] = in_hit ? in_dist : 10'h3FF;
          m_filled[in_idx] = 1;
          if (filled_count() == SLOTS) m_phase = 2;
        end
      end else if (m_phase == 2 && out_ack) begin
        m_phase = 0;
      end
    end
  end

  always @(negedge clk) begin
    check("cyc_out_valid", BUSW'(out_valid), BUSW'(m_phase == 2));
    check("cyc_in_ready",  BUSW'(in_ready),  BUSW'(m_phase == 1));
    check("cyc_busy",      BUSW'(busy),      BUSW'(m_phase != 0));
    check("cyc_dup_err",   BUSW'(dup_err),   BUSW'(m_dup));
    check("cyc_out_bus",   out_bus,          model_bus());
  end

  localparam logic [BUSW-1:0] ALL_MISS = {SLOTS{10'h3FF}};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wr(input int idx, input bit hit, input int d);
    in_valid = 1'b1;
    in_idx   = idx[WIDTH-1:0];
    in_hit   = hit;
    in_dist  = d[LENGTH-1:0];
    step();
    in_valid = 1'b0;
  endtask

  task automatic ack();
    out_ack = 1'b1;
    step();
    out_ack = 1'b0;
  endtask

  initial begin
    logic [BUSW-1:0] held;
    int order [8] = '{5, 2, 7, 0, 1, 3, 4, 6};
    int budget;

    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_idx = '0;
    in_hit = 1'b0; in_dist = '0; out_ack = 1'b0;
    step(); step();
    rst_n = 1'b1;
    check("rst_out_valid", BUSW'(out_valid), '0);
    check("rst_bus", out_bus, ALL_MISS);
    step();

    // T2: ordered fill
    do_start();
    for (int i = 0; i < SLOTS; i++) begin
      wr(i, 1, 100 - 10 * i);
      if (i == 6) check("t2_not_done_early", BUSW'(out_valid), '0);
    end
    check("t2_valid", BUSW'(out_valid), 1);
    check("t2_slot3", BUSW'(out_bus[39:30]), 70);
    check("t2_slot7", BUSW'(out_bus[79:70]), 30);
    check("t2_argmin", BUSW'(argmin(out_bus)), 7);

    // T5: handshake hold, with ignored input offers
    held = out_bus;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; in_idx = 3'd0; in_hit = 1'b1; in_dist = 10'd1;
      step();
      check("t5_bus_stable", out_bus, held);
      check("t5_in_ready", BUSW'(in_ready), '0);
      check("t5_no_dup", BUSW'(dup_err), '0);
    end
    in_valid = 1'b0;
    ack();
    check("t5_valid_fell", BUSW'(out_valid), '0);
    check("t5_idle", BUSW'(busy), '0);
    check("t5_bus_kept", BUSW'(out_bus[9:0]), 100);

    // T3: shuffled order with misses on 2 and 6
    do_start();
    check("t3_cleared", out_bus, ALL_MISS);
    for (int k = 0; k < SLOTS; k++) begin
      wr(order[k], !(order[k] == 2 || order[k] == 6), 200 + order[k] * 7);
      check("t3_valid_timing", BUSW'(out_valid), BUSW'(k == 7));
    end
    check("t3_slot2_miss", BUSW'(out_bus[29:20]), 10'h3FF);
    check("t3_slot6_miss", BUSW'(out_bus[69:60]), 10'h3FF);
    check("t3_slot5", BUSW'(out_bus[59:50]), 235);
    check("t3_argmin", BUSW'(argmin(out_bus)), 0);
    ack();

    // T4: duplicate index
    do_start();
    wr(4, 1, 20);
    check("t4_first_no_dup", BUSW'(dup_err), '0);
    wr(4, 1, 5);
    check("t4_dup_pulse", BUSW'(dup_err), 1);
    step();
    check("t4_dup_one_cycle", BUSW'(dup_err), '0);
    check("t4_slot4_kept", BUSW'(out_bus[49:40]), 20);
    for (int i = 0; i < SLOTS; i++) begin
      if (i != 4) begin
        wr(i, 1, 50 + i);
        check("t4_valid_timing", BUSW'(out_valid), BUSW'(i == 7));
      end
    end

    // T6: start together with out_ack while presenting
    start = 1'b1; out_ack = 1'b1;
    step();
    start = 1'b0; out_ack = 1'b0;
    check("t6_collect", BUSW'(in_ready), 1);
    check("t6_not_valid", BUSW'(out_valid), '0);
    check("t6_cleared", out_bus, ALL_MISS);
    for (int i = SLOTS - 1; i >= 0; i--) wr(i, 1, i * 3 + 1);
    check("t6_done", BUSW'(out_valid), 1);
    check("t6_argmin", BUSW'(argmin(out_bus)), 0);
    ack();

    // T1: async reset mid-collect, between clock edges
    do_start();
    wr(1, 1, 5);
    wr(3, 1, 6);
    #3 rst_n = 1'b0;
    #1;
    check("t1_out_valid", BUSW'(out_valid), '0);
    check("t1_in_ready", BUSW'(in_ready), '0);
    check("t1_busy", BUSW'(busy), '0);
    check("t1_bus", out_bus, ALL_MISS);
    step();
    rst_n = 1'b1;
    step();

    // Randomized frames: random indices (duplicates included), gaps, misses, aborts.
    for (int f = 0; f < 25; f++) begin
      do_start();
      budget = 0;
      while (!out_valid && budget < 400) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_idx   = WIDTH'($urandom);
        in_hit   = ($urandom_range(0, 4) != 0);
        in_dist  = LENGTH'($urandom);
        start    = ($urandom_range(0, 60) == 0);
        out_ack  = $urandom_range(0, 1);
        step();
        budget++;
      end
      in_valid = 1'b0; start = 1'b0; out_ack = 1'b0;
      if (budget >= 400) check("rand_frame_timeout", BUSW'(out_valid), 1);
      for (int c = $urandom_range(0, 4); c > 0; c--) begin
        in_valid = $urandom_range(0, 1);
        in_idx   = WIDTH'($urandom);
        step();
      end
      in_valid = 1'b0;
      if ($urandom_range(0, 2) == 0) begin
        start = 1'b1; out_ack = 1'b1;
        step();
        start = 1'b0; out_ack = 1'b0;
      end else begin
        ack();
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
